// File: rtl/ext_razor_collector.sv
// ext_razor_collector: repairs razor-flagged extrinsics, buffers one frame and drains it via ready/valid; RAZOR_CORRECT_EN enables repair and Stall.
module ext_razor_collector #(
  parameter int M        = 6,
  parameter int RazorBit = 1,
  parameter int FRAME    = 40,
  parameter int CW       = 8
) (
  input  logic          Clock,
  input  logic          nReset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [M-1:0]  be1,
  input  logic          Error_be1,
  output logic          Stall,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [M-1:0]  out_data,
  output logic          out_last,
  output logic [CW-1:0] err_count,
  output logic          busy
);
  localparam int PW = $clog2(FRAME);
  typedef enum logic {FILL, DRAIN} state_t;
  state_t state, state_nxt;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [M-1:0] mem [FRAME];
  logic [M-1:0] fixed;
  logic accept, take, last_wr;
`ifdef RAZOR_CORRECT_EN
  assign in_ready = (state == FILL) && !Stall;
  assign fixed = Error_be1 ? (be1 ^ (M'(1) << (M - RazorBit))) : be1;
  // The flag means the main flop missed the late transition, so flipping it recovers the shadow value.
  always_ff @(posedge Clock or negedge nReset)
    if (!nReset) Stall <= 1'b0;
    else Stall <= accept && Error_be1;
`else
  assign in_ready = (state == FILL);
  assign fixed = be1;
  assign Stall = 1'b0;
`endif
  assign accept = in_valid && in_ready;
  assign take = out_valid && out_ready;
  assign last_wr = wr_ptr == PW'(FRAME - 1);
  assign out_valid = (state == DRAIN);
  assign busy = (state == DRAIN);
  assign out_last = (state == DRAIN) && (rd_ptr == PW'(FRAME - 1));
  assign out_data = (state == DRAIN) ? mem[rd_ptr] : '0;
  always_ff @(posedge Clock or negedge nReset)
    if (!nReset) state <= FILL;
    else state <= state_nxt;
  always_comb
    state_nxt = (state == FILL) ? ((accept && last_wr) ? DRAIN : FILL)
                                : ((take && out_last) ? FILL : DRAIN);
  always_ff @(posedge Clock or negedge nReset)
    if (!nReset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      err_count <= '0;
    end else begin
      if (accept) wr_ptr <= last_wr ? '0 : wr_ptr + PW'(1);
      if (accept && last_wr) rd_ptr <= '0;
      else if (take) rd_ptr <= out_last ? '0 : rd_ptr + PW'(1);
      if (take && out_last) err_count <= '0;
      else if (accept && Error_be1 && err_count != '1) err_count <= err_count + CW'(1);
    end
  always_ff @(posedge Clock)
    if (accept) mem[wr_ptr] <= fixed;
endmodule

// File: tb/tb_ext_razor_collector.sv
// tb_ext_razor_collector: random and directed frames checked every cycle against a queue-based frame model.
module tb_ext_razor_collector;
  localparam int M = 6, RB = 1, FRAME = 40, CW = 2;
  logic Clock = 0, nReset = 1, in_valid = 0, Error_be1 = 0, out_ready = 0;
  logic [M-1:0] be1 = '0;
  logic in_ready, Stall, out_valid, out_last, busy;
  logic [M-1:0] out_data;
  logic [CW-1:0] err_count;
  int errors = 0, checks = 0;
  logic [M-1:0] vals [FRAME];
  logic errs [FRAME];
  logic [M-1:0] rx [FRAME];
  logic lst [FRAME];
  logic [M-1:0] q [$];
  bit m_drain = 0, m_stall = 0;
  int m_rd = 0, m_err = 0;

  ext_razor_collector #(.M(M), .RazorBit(RB), .FRAME(FRAME), .CW(CW)) dut (
    .Clock(Clock), .nReset(nReset), .in_valid(in_valid), .in_ready(in_ready),
    .be1(be1), .Error_be1(Error_be1), .Stall(Stall), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .err_count(err_count), .busy(busy));

  always #5 Clock = ~Clock;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [M-1:0] fix(logic [M-1:0] v, logic e);
    logic [M-1:0] r = v;
`ifdef RAZOR_CORRECT_EN
    if (e) r[M-RB] = ~r[M-RB];
`endif
    return r;
  endfunction

  function automatic bit m_in_ready();
`ifdef RAZOR_CORRECT_EN
    return !m_drain && !m_stall;
`else
    return !m_drain;
`endif
  endfunction

  // Frame-level model: a queue of stored samples plus a read index while draining.
  always @(posedge Clock or negedge nReset) begin : model
    bit acc;
    if (!nReset) begin
      q.delete(); m_drain = 0; m_rd = 0; m_stall = 0; m_err = 0;
    end else begin
      acc = in_valid && m_in_ready();
      if (m_drain) begin
        if (out_ready) begin
          if (m_rd == FRAME - 1) begin q.delete(); m_drain = 0; m_rd = 0; m_err = 0; end
          else m_rd++;
        end
      end else if (acc) begin
        q.push_back(fix(be1, Error_be1));
        if (Error_be1 && m_err < (1 << CW) - 1) m_err++;
        if (q.size() == FRAME) begin m_drain = 1; m_rd = 0; end
      end
`ifdef RAZOR_CORRECT_EN
      m_stall = acc && Error_be1;
`else
      m_stall = 0;
`endif
    end
  end

  always @(negedge Clock) begin
    chk("in_ready", in_ready, m_in_ready());
    chk("out_valid", out_valid, m_drain);
    chk("busy", busy, m_drain);
    chk("out_last", out_last, m_drain && m_rd == FRAME - 1);
    chk("out_data", out_data, m_drain ? q[m_rd] : '0);
    chk("stall", Stall, m_stall);
    chk("err_count", err_count, m_err);
  end

  task automatic tick();
    @(posedge Clock);
    #2;
  endtask

  task automatic send_frame(int gap_pct);
    for (int i = 0; i < FRAME; i++) begin
      bit acc = 0;
      int n = 0;
      while (!acc) begin
        if ($urandom_range(99) < gap_pct) begin
          in_valid = 0; be1 = M'($urandom); Error_be1 = 1'($urandom);
          tick();
        end else begin
          in_valid = 1; be1 = vals[i]; Error_be1 = errs[i];
          @(negedge Clock);
          acc = in_ready;
          tick();
        end
        if (++n > 60 && !acc) begin chk("accept_timeout", n, 0); acc = 1; end
      end
    end
    in_valid = 0; Error_be1 = 0;
  endtask

  task automatic drain(int mode, int nmax);
    int got = 0, cyc = 0;
    bit ph = 1;
    while (got < nmax && cyc < 400) begin
      out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? ph : 1'($urandom);
      ph = !ph;
      in_valid = 1'($urandom); be1 = M'($urandom); Error_be1 = 1'($urandom);
      @(negedge Clock);
      if (out_valid && out_ready) begin rx[got] = out_data; lst[got] = out_last; got++; end
      tick();
      cyc++;
    end
    if (got < nmax) chk("drain_timeout", got, nmax);
    out_ready = 0; in_valid = 0; Error_be1 = 0;
  endtask

  task automatic rand_frame(int err_pct);
    for (int i = 0; i < FRAME; i++) begin
      vals[i] = M'($urandom);
      errs[i] = $urandom_range(99) < err_pct;
    end
  endtask

  initial begin
    #1 nReset = 0;
    #1 chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    repeat (2) tick();
    nReset = 1;
    tick();
    for (int i = 0; i < FRAME; i++) begin vals[i] = M'(i); errs[i] = 0; end
    send_frame(0);
    chk("f1_err", err_count, 0);
    drain(0, FRAME);
    for (int i = 0; i < FRAME; i++) begin
      chk("f1_data", rx[i], i);
      chk("f1_last", lst[i], i == FRAME - 1);
    end
    vals[3] = 6'b000010; errs[3] = 1; errs[FRAME-1] = 1;
    send_frame(30);
`ifdef RAZOR_CORRECT_EN
    chk("f2_stall_drain", Stall, 1);
`else
    chk("f2_stall_drain", Stall, 0);
`endif
    chk("f2_in_ready", in_ready, 0);
    chk("f2_err", err_count, 2);
    drain(1, FRAME);
`ifdef RAZOR_CORRECT_EN
    chk("f2_s3", rx[3], 6'b100010);
    chk("f2_s39", rx[FRAME-1], 7);
`else
    chk("f2_s3", rx[3], 6'b000010);
    chk("f2_s39", rx[FRAME-1], 39);
`endif
    chk("f2_err_clr", err_count, 0);
    rand_frame(0);
    for (int i = 0; i < 5; i++) errs[i*5] = 1;
    send_frame(20);
    chk("f3_sat", err_count, 3);
    drain(2, FRAME);
    rand_frame(25);
    errs[0] = 1;
    send_frame(0);
    drain(0, 5);
    #1 nReset = 0;
    #1 chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_err", err_count, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_stall", Stall, 0);
    tick();
    nReset = 1;
    tick();
    rand_frame(20);
    send_frame(10);
    drain(0, 1);
    chk("post_rst_first", rx[0], fix(vals[0], errs[0]));
    drain(2, FRAME - 1);
    for (int f = 0; f < 8; f++) begin
      rand_frame($urandom_range(40));
      send_frame($urandom_range(50));
      drain(2, FRAME);
    end
    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
